fb_pixel_writer: RTL and testbench

- Write side of the video RAM that the VGA display path scans out; it turns CPU/debug pixel commands into read-modify-write cycles on one RAM word.
- Memory-pixel grid is MEM_COLS x MEM_ROWS. Each memory pixel is 2^BITS_PER_MEMORY_PIXEL_X by 2^BITS_PER_MEMORY_PIXEL_Y screen pixels inside the 512x384 active window.
- Also provides a full-screen clear sweep.

---
 rtl/fb_pixel_writer.sv | 198 +++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
// Write side of the video RAM scanned out by the VGA display path. Pixel
// commands from a CPU/debug master become read-modify-write cycles on a
// single RAM word (one bit per memory pixel, leftmost pixel in the MSB).
// A whole-word fill skips the read, and a clear sweep zeroes every word.
//
// Ports:
//   CLK_50, RESET          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_op                 00 clear, 01 set, 10 toggle, 11 fill word
//   cmd_x, cmd_y           memory-pixel column / row
//   cmd_data               word value for the fill op
//   clear_all              request to zero the whole framebuffer
//   ram_addr, ram_rd_en,   synchronous RAM port (read data valid one
//   ram_rdata, ram_wr_en,  cycle after ram_rd_en)
//   ram_wdata
//   busy                   block is not idle
//   err_oob                one-cycle pulse: command dropped, out of range
//   clear_done             one-cycle pulse at the end of a clear sweep
module fb_pixel_writer #(
    parameter int RAM_WIDTH               = 16,
    parameter int BITS_PER_MEMORY_PIXEL_X = 3,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 3,
    parameter int ADDR_WIDTH              = 8
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [9:0]            cmd_x,
    input  logic [9:0]            cmd_y,
    input  logic [RAM_WIDTH-1:0]  cmd_data,
    input  logic                  clear_all,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd_en,
    input  logic [RAM_WIDTH-1:0]  ram_rdata,
    output logic                  ram_wr_en,
    output logic [RAM_WIDTH-1:0]  ram_wdata,
    output logic                  busy,
    output logic                  err_oob,
    output logic                  clear_done
);

    localparam int MEM_COLS      = 512 >> BITS_PER_MEMORY_PIXEL_X;
    localparam int MEM_ROWS      = 384 >> BITS_PER_MEMORY_PIXEL_Y;
    localparam int WORDS_PER_ROW = MEM_COLS / RAM_WIDTH;
    localparam int WORDS_TOTAL   = WORDS_PER_ROW * MEM_ROWS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // Single-bit mask for a bit index inside a RAM word.
    function automatic logic [RAM_WIDTH-1:0] pixel_mask(input int idx);
        pixel_mask = {{(RAM_WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Apply a pixel op to a word; only bits under the mask may change.
    function automatic logic [RAM_WIDTH-1:0] apply_op(
        input logic [1:0]           op,
        input logic [RAM_WIDTH-1:0] word,
        input logic [RAM_WIDTH-1:0] mask
    );
        case (op)
            2'b00:   apply_op = word & ~mask;
            2'b01:   apply_op = word | mask;
            2'b10:   apply_op = word ^ mask;
            default: apply_op = word;
        endcase
    endfunction

    state_t                  state_r, state_s;
    logic [1:0]              op_r, op_s;
    logic [RAM_WIDTH-1:0]    mask_r, mask_s;
    logic [ADDR_WIDTH-1:0]   ram_addr_r, ram_addr_s;
    logic                    ram_rd_en_r, ram_rd_en_s;
    logic                    ram_wr_en_r, ram_wr_en_s;
    logic [RAM_WIDTH-1:0]    ram_wdata_r, ram_wdata_s;
    logic                    err_oob_r, err_oob_s;
    logic                    clear_done_r, clear_done_s;

    logic                    cmd_ready_s;
    logic                    in_range_s;
    int                      word_s;
    int                      bit_idx_s;

    assign cmd_ready_s = (state_r == ST_IDLE) && !clear_all;
    assign in_range_s  = (int'(cmd_x) < MEM_COLS) && (int'(cmd_y) < MEM_ROWS);
    assign word_s      = int'(cmd_y) * WORDS_PER_ROW + int'(cmd_x) / RAM_WIDTH;
    assign bit_idx_s   = RAM_WIDTH - 1 - (int'(cmd_x) % RAM_WIDTH);

    // Next-state and next-output decode; every RAM strobe is registered.
    always_comb begin
        state_s      = state_r;
        op_s         = op_r;
        mask_s       = mask_r;
        ram_addr_s   = ram_addr_r;
        ram_rd_en_s  = 1'b0;
        ram_wr_en_s  = 1'b0;
        ram_wdata_s  = ram_wdata_r;
        err_oob_s    = 1'b0;
        clear_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_all) begin
                    // Sweep starts writing word 0 in its first cycle.
                    state_s     = ST_CLEAR;
                    ram_addr_s  = {ADDR_WIDTH{1'b0}};
                    ram_wr_en_s = 1'b1;
                    ram_wdata_s = {RAM_WIDTH{1'b0}};
                end else if (cmd_valid) begin
                    op_s   = cmd_op;
                    mask_s = pixel_mask(bit_idx_s);
                    if (!in_range_s) begin
                        // Dropped command: no RAM access, stay ready.
                        err_oob_s = 1'b1;
                    end else if (cmd_op == 2'b11) begin
                        state_s     = ST_WRITE;
                        ram_addr_s  = ADDR_WIDTH'(word_s);
                        ram_wr_en_s = 1'b1;
                        ram_wdata_s = cmd_data;
                    end else begin
                        state_s     = ST_READ;
                        ram_addr_s  = ADDR_WIDTH'(word_s);
                        ram_rd_en_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // ram_rdata now holds the word requested in READ.
                state_s     = ST_WRITE;
                ram_wr_en_s = 1'b1;
                ram_wdata_s = apply_op(op_r, ram_rdata, mask_r);
            end
            ST_WRITE: begin
                state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (ram_addr_r == ADDR_WIDTH'(WORDS_TOTAL - 1)) begin
                    state_s      = ST_IDLE;
                    clear_done_s = 1'b1;
                end else begin
                    ram_addr_s  = ram_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    ram_wr_en_s = 1'b1;
                    ram_wdata_s = {RAM_WIDTH{1'b0}};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            op_r         <= 2'b00;
            mask_r       <= {RAM_WIDTH{1'b0}};
            ram_addr_r   <= {ADDR_WIDTH{1'b0}};
            ram_rd_en_r  <= 1'b0;
            ram_wr_en_r  <= 1'b0;
            ram_wdata_r  <= {RAM_WIDTH{1'b0}};
            err_oob_r    <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            op_r         <= op_s;
            mask_r       <= mask_s;
            ram_addr_r   <= ram_addr_s;
            ram_rd_en_r  <= ram_rd_en_s;
            ram_wr_en_r  <= ram_wr_en_s;
            ram_wdata_r  <= ram_wdata_s;
            err_oob_r    <= err_oob_s;
            clear_done_r <= clear_done_s;
        end
    end

    assign cmd_ready  = cmd_ready_s;
    assign busy       = (state_r != ST_IDLE);
    assign ram_addr   = ram_addr_r;
    assign ram_rd_en  = ram_rd_en_r;
    assign ram_wr_en  = ram_wr_en_r;
    assign ram_wdata  = ram_wdata_r;
    assign err_oob    = err_oob_r;
    assign clear_done = clear_done_r;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: a synchronous RAM model, a
// pixel-grid reference model and one task per scenario.
module tb_fb_pixel_writer;

    logic        CLK_50 = 1'b0;
    logic        RESET  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [9:0]  cmd_x = 10'd0;
    logic [9:0]  cmd_y = 10'd0;
    logic [15:0] cmd_data = 16'h0000;
    logic        clear_all = 1'b0;
    logic [7:0]  ram_addr;
    logic        ram_rd_en;
    logic [15:0] ram_rdata = 16'h0000;
    logic        ram_wr_en;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        err_oob;
    logic        clear_done;

    int errors = 0;
    int checks = 0;

    fb_pixel_writer dut (
        .CLK_50(CLK_50), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data),
        .clear_all(clear_all),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
        .ram_wr_en(ram_wr_en), .ram_wdata(ram_wdata),
        .busy(busy), .err_oob(err_oob), .clear_done(clear_done)
    );

    always #10 CLK_50 = ~CLK_50;

    // RAM model plus bus logging
    logic [15:0] mem [0:255];
    logic [23:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int          both_cnt = 0;
    int          err_cnt = 0;
    int          done_cnt = 0;

    always @(posedge CLK_50) begin
        if (ram_rd_en) begin ram_rdata <= mem[ram_addr]; rd_q.push_back(ram_addr); end
        if (ram_wr_en) begin mem[ram_addr] <= ram_wdata; wr_q.push_back({ram_addr, ram_wdata}); end
        if (ram_rd_en && ram_wr_en) both_cnt++;
        if (err_oob) err_cnt++;
        if (clear_done) done_cnt++;
    end

    // Reference model: one bit per memory pixel, 64 columns x 48 rows
    logic pix [0:47][0:63];

    function automatic logic [15:0] exp_word(input int addr);
        logic [15:0] w;
        int row, col;
        row = addr / 4;
        col = addr % 4;
        for (int b = 0; b < 16; b++) w[15-b] = pix[row][col*16+b];
        return w;
    endfunction

    task automatic model_apply(input logic [1:0] op, input int x, input int y, input logic [15:0] d);
        if (x < 64 && y < 48) begin
            case (op)
                2'b00: pix[y][x] = 1'b0;
                2'b01: pix[y][x] = 1'b1;
                2'b10: pix[y][x] = ~pix[y][x];
                default: for (int b = 0; b < 16; b++) pix[y][(x/16)*16+b] = d[15-b];
            endcase
        end
    endtask

    // Offer a command (starting at a negedge), wait for acceptance, then
    // count negedges until cmd_ready returns. Returns on a negedge.
    task automatic issue(input logic [1:0] op, input int x, input int y, input logic [15:0] d,
                         output int lat, output bit to);
        int w;
        to = 1'b0; lat = 0; w = 0;
        cmd_op = op; cmd_x = 10'(x); cmd_y = 10'(y); cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && w < 400) begin @(negedge CLK_50); w++; end
        if (!cmd_ready) begin
            to = 1'b1;
            cmd_valid = 1'b0;
        end else begin
            @(negedge CLK_50);
            cmd_valid = 1'b0;
            lat = 1;
            while (!cmd_ready && lat < 50) begin @(negedge CLK_50); lat++; end
            if (!cmd_ready) to = 1'b1;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(negedge CLK_50);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({ram_rd_en, ram_wr_en, err_oob, clear_done} !== 4'b0000) begin errors++;
            $display("FAIL reset_strobes got=%b exp=0000", {ram_rd_en, ram_wr_en, err_oob, clear_done}); end
        checks++; if ({ram_addr, ram_wdata} !== 24'h0) begin errors++;
            $display("FAIL reset_addr_data got=%h exp=000000", {ram_addr, ram_wdata}); end
        RESET = 1'b0;
        @(negedge CLK_50);
        checks++; if (ram_rd_en !== 1'b0 || ram_wr_en !== 1'b0) begin errors++;
            $display("FAIL reset_release_strobe got=%b%b exp=00", ram_rd_en, ram_wr_en); end
    endtask

    task automatic test_clear_all;
        int wb, rb, dc, bad, n, lat;
        bit to;
        wb = wr_q.size(); rb = rd_q.size(); dc = done_cnt; bad = 0; n = 0;
        cmd_op = 2'b01; cmd_x = 10'd5; cmd_y = 10'd1; cmd_data = 16'h0; cmd_valid = 1'b1;
        clear_all = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_blocked got=%b exp=0", cmd_ready); end
        @(negedge CLK_50);
        clear_all = 1'b0;
        checks++; if (busy !== 1'b1 || ram_wr_en !== 1'b1 || ram_addr !== 8'd0) begin errors++;
            $display("FAIL clear_start got busy=%b wr=%b addr=%0d exp 1 1 0", busy, ram_wr_en, ram_addr); end
        while (!cmd_ready && n < 400) begin @(negedge CLK_50); n++; end
        checks++; if (!cmd_ready) begin errors++; $display("FAIL clear_timeout got=%0d cycles exp<400", n); end
        checks++; if (clear_done !== 1'b1) begin errors++; $display("FAIL clear_done_pulse got=%b exp=1", clear_done); end
        checks++; if (wr_q.size() - wb != 192) begin errors++;
            $display("FAIL clear_write_count got=%0d exp=192", wr_q.size() - wb); end
        for (int i = 0; i < 192 && wb + i < wr_q.size(); i++)
            if (wr_q[wb+i] !== {8'(i), 16'h0000}) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sequence got=%0d bad writes exp=0", bad); end
        checks++; if (rd_q.size() != rb) begin errors++; $display("FAIL clear_no_read got=%0d reads exp=0", rd_q.size() - rb); end
        for (int y = 0; y < 48; y++) for (int x = 0; x < 64; x++) pix[y][x] = 1'b0;
        // Held command is taken now that the sweep is over.
        wb = wr_q.size();
        @(negedge CLK_50);
        cmd_valid = 1'b0;
        lat = 1;
        while (!cmd_ready && lat < 50) begin @(negedge CLK_50); lat++; end
        model_apply(2'b01, 5, 1, 16'h0);
        checks++; if (clear_done !== 1'b0 || done_cnt - dc != 1) begin errors++;
            $display("FAIL clear_done_once got=%0d pulses exp=1", done_cnt - dc); end
        checks++; if (lat != 4 || wr_q.size() - wb != 1 || wr_q[wr_q.size()-1] !== {8'd4, 16'h0400}) begin errors++;
            $display("FAIL clear_then_cmd got lat=%0d last=%h exp lat=4 last=040400", lat, wr_q[wr_q.size()-1]); end
    endtask

    task automatic test_set_origin;
        int wb, rb, lat;
        bit to;
        wb = wr_q.size(); rb = rd_q.size();
        issue(2'b01, 0, 0, 16'h0, lat, to);
        model_apply(2'b01, 0, 0, 16'h0);
        checks++; if (to || lat != 4) begin errors++; $display("FAIL set_latency got=%0d exp=4", lat); end
        checks++; if (rd_q.size() - rb != 1 || rd_q[rd_q.size()-1] !== 8'd0) begin errors++;
            $display("FAIL set_read got=%0d reads exp=1 at addr 0", rd_q.size() - rb); end
        checks++; if (wr_q.size() - wb != 1 || wr_q[wr_q.size()-1] !== {8'd0, 16'h8000}) begin errors++;
            $display("FAIL set_write got=%h exp=008000", wr_q[wr_q.size()-1]); end
    endtask

    task automatic test_toggle;
        int wb, lat;
        bit to;
        issue(2'b11, 16, 2, 16'hFFFF, lat, to);
        model_apply(2'b11, 16, 2, 16'hFFFF);
        wb = wr_q.size();
        issue(2'b10, 17, 2, 16'h0, lat, to);
        model_apply(2'b10, 17, 2, 16'h0);
        checks++; if (to || wr_q.size() - wb != 1 || wr_q[wr_q.size()-1] !== {8'd9, 16'hBFFF}) begin errors++;
            $display("FAIL toggle_first got=%h exp=09bfff", wr_q[wr_q.size()-1]); end
        wb = wr_q.size();
        issue(2'b10, 17, 2, 16'h0, lat, to);
        model_apply(2'b10, 17, 2, 16'h0);
        checks++; if (to || wr_q.size() - wb != 1 || wr_q[wr_q.size()-1] !== {8'd9, 16'hFFFF}) begin errors++;
            $display("FAIL toggle_second got=%h exp=09ffff", wr_q[wr_q.size()-1]); end
    endtask

    task automatic test_fill;
        int wb, rb, lat;
        bit to;
        wb = wr_q.size(); rb = rd_q.size();
        issue(2'b11, 63, 47, 16'hA5A5, lat, to);
        model_apply(2'b11, 63, 47, 16'hA5A5);
        checks++; if (to || lat != 2) begin errors++; $display("FAIL fill_latency got=%0d exp=2", lat); end
        checks++; if (rd_q.size() != rb) begin errors++; $display("FAIL fill_no_read got=%0d reads exp=0", rd_q.size() - rb); end
        checks++; if (wr_q.size() - wb != 1 || wr_q[wr_q.size()-1] !== {8'd191, 16'hA5A5}) begin errors++;
            $display("FAIL fill_write got=%h exp=bfa5a5", wr_q[wr_q.size()-1]); end
    endtask

    task automatic test_back_to_back_oob;
        int wb, rb, ec, lat;
        bit to;
        wb = wr_q.size(); rb = rd_q.size(); ec = err_cnt;
        issue(2'b01, 64, 0, 16'h0, lat, to);
        checks++; if (to || lat != 1 || err_oob !== 1'b1) begin errors++;
            $display("FAIL oob_x got lat=%0d err=%b exp lat=1 err=1", lat, err_oob); end
        issue(2'b01, 0, 48, 16'h0, lat, to);
        checks++; if (to || lat != 1 || err_oob !== 1'b1) begin errors++;
            $display("FAIL oob_y got lat=%0d err=%b exp lat=1 err=1", lat, err_oob); end
        @(negedge CLK_50);
        checks++; if (err_oob !== 1'b0 || err_cnt - ec != 2) begin errors++;
            $display("FAIL oob_pulse got err=%b cycles=%0d exp 0 and 2", err_oob, err_cnt - ec); end
        checks++; if (wr_q.size() != wb || rd_q.size() != rb) begin errors++;
            $display("FAIL oob_no_ram got=%0d accesses exp=0", wr_q.size() - wb + rd_q.size() - rb); end
    endtask

    task automatic test_random;
        int wb, rb, lat, x, y, exp_lat, exp_w, exp_r, bad;
        logic [1:0] op;
        logic [15:0] d;
        bit to, oob;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            x = $urandom_range(0, 70);
            y = $urandom_range(0, 52);
            d = 16'($urandom);
            wb = wr_q.size(); rb = rd_q.size();
            issue(op, x, y, d, lat, to);
            model_apply(op, x, y, d);
            oob = (x >= 64) || (y >= 48);
            exp_lat = oob ? 1 : ((op == 2'b11) ? 2 : 4);
            exp_w = oob ? 0 : 1;
            exp_r = (oob || op == 2'b11) ? 0 : 1;
            checks++; if (to || lat != exp_lat || wr_q.size() - wb != exp_w || rd_q.size() - rb != exp_r) begin
                errors++;
                $display("FAIL rand_shape op=%0d x=%0d y=%0d got lat=%0d w=%0d r=%0d exp %0d %0d %0d",
                         op, x, y, lat, wr_q.size() - wb, rd_q.size() - rb, exp_lat, exp_w, exp_r);
            end
            if (!oob && wr_q.size() - wb == 1) begin
                checks++; if (wr_q[wb] !== {8'(y*4 + x/16), exp_word(y*4 + x/16)}) begin errors++;
                    $display("FAIL rand_write op=%0d x=%0d y=%0d got=%h exp=%h", op, x, y, wr_q[wb],
                             {8'(y*4 + x/16), exp_word(y*4 + x/16)}); end
            end
        end
        for (int a = 0; a < 192; a++) if (mem[a] !== exp_word(a)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_memory got=%0d bad words exp=0", bad); end
    endtask

    task automatic test_reset_in_wait;
        int wb, n;
        wb = wr_q.size(); n = 0;
        cmd_op = 2'b01; cmd_x = 10'd3; cmd_y = 10'd3; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(negedge CLK_50); n++; end
        @(negedge CLK_50);          // READ
        cmd_valid = 1'b0;
        @(negedge CLK_50);          // WAIT
        RESET = 1'b1;
        #1;
        checks++; if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || ram_addr !== 8'd0) begin
            errors++;
            $display("FAIL rst_wait_outputs got wr=%b rd=%b busy=%b rdy=%b addr=%0d exp 0 0 0 1 0",
                     ram_wr_en, ram_rd_en, busy, cmd_ready, ram_addr);
        end
        @(negedge CLK_50);
        RESET = 1'b0;
        repeat (4) @(negedge CLK_50);
        checks++; if (wr_q.size() != wb) begin errors++; $display("FAIL rst_wait_no_write got=%0d writes exp=0", wr_q.size() - wb); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready got=%b exp=1", cmd_ready); end
        checks++; if (mem[12] !== exp_word(12)) begin errors++; $display("FAIL rst_wait_word got=%h exp=%h", mem[12], exp_word(12)); end
    endtask

    initial begin
        for (int y = 0; y < 48; y++) for (int x = 0; x < 64; x++) pix[y][x] = 1'b0;
        @(negedge CLK_50);
        test_reset();
        test_clear_all();
        test_set_origin();
        test_toggle();
        test_fill();
        test_back_to_back_oob();
        test_random();
        test_reset_in_wait();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_exclusive got=%0d overlaps exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
